// File: rtl/spram_arbiter.sv
// Two-port req/ack arbiter sharing one 32K x 8 synchronous SPRAM.
// Port 0 (CPU) normally wins; port 1 (video/DMA) has a starvation guard.
//
// Ports:
//   clk, reset          rising-edge clock, sync active-high reset
//   pN_req/addr/we/wdata request side of port N (held until ack)
//   pN_ack              combinational accept, transfer on req&ack
//   pN_rdata/rvalid     registered read return, 2 edges after accept
//   mem_addr/we/wdata   registered RAM controls
//   mem_rdata           RAM output for address sampled last edge
//
// Parameters:
//   FIXED_PRIORITY  1: port 0 wins conflicts (starvation guarded)
//                   0: round-robin
//   STARVE_LIMIT    stalled cycles before port 1 is forced through

module spram_arbiter #(
  parameter int FIXED_PRIORITY = 1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [14:0] p0_addr,
  input  logic        p0_we,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic [14:0] p1_addr,
  input  logic        p1_we,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic        p1_rvalid,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt;
  logic        last_p1;
  logic        p1_wins;
  logic        sel1;
  logic        xfer;
  logic        w_we;
  logic [14:0] w_addr;
  logic [7:0]  w_wdata;

  // Read tags: {valid, port}. Stage 1 holds the accepted read while
  // the RAM samples its address; stage 2 lines up with mem_rdata.
  logic        tag1_v;
  logic        tag1_p;
  logic        tag2_v;
  logic        tag2_p;

  // Who takes a conflict this cycle.
  always_comb begin
    p1_wins = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      p1_wins = (starve_cnt == LIMIT);
    end else begin
      p1_wins = !last_p1;
    end
  end

  assign sel1    = p1_req && (!p0_req || p1_wins);
  assign p0_ack  = !reset && p0_req && !sel1;
  assign p1_ack  = !reset && sel1;
  assign xfer    = p0_ack || p1_ack;

  assign w_we    = sel1 ? p1_we    : p0_we;
  assign w_addr  = sel1 ? p1_addr  : p0_addr;
  assign w_wdata = sel1 ? p1_wdata : p0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      starve_cnt <= '0;
      last_p1    <= 1'b1;
      tag1_v     <= 1'b0;
      tag1_p     <= 1'b0;
      tag2_v     <= 1'b0;
      tag2_p     <= 1'b0;
    end else begin
      // mem_we pulses once per accepted write.
      mem_we <= xfer && w_we;
      if (xfer) begin
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
        last_p1   <= sel1;
      end

      tag1_v <= xfer && !w_we;
      tag1_p <= sel1;
      tag2_v <= tag1_v;
      tag2_p <= tag1_p;

      p0_rvalid <= tag2_v && !tag2_p;
      p1_rvalid <= tag2_v && tag2_p;
      if (tag2_v && !tag2_p) begin
        p0_rdata <= mem_rdata;
      end
      if (tag2_v && tag2_p) begin
        p1_rdata <= mem_rdata;
      end

      // Count port 1 stalls, saturating at the limit.
      if (p1_ack) begin
        starve_cnt <= '0;
      end else if (p1_req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Testbench for spram_arbiter: fixed-priority and round-robin
// instances, each with its own behavioural SPRAM.

module tb_spram_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [14:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;

  logic        a_p0_ack, a_p1_ack, a_p0_rvalid, a_p1_rvalid;
  logic [7:0]  a_p0_rdata, a_p1_rdata;
  logic [14:0] a_mem_addr;
  logic        a_mem_we;
  logic [7:0]  a_mem_wdata, a_mem_rdata;

  logic        b_p0_ack, b_p1_ack, b_p0_rvalid, b_p1_rvalid;
  logic [7:0]  b_p0_rdata, b_p1_rdata;
  logic [14:0] b_mem_addr;
  logic        b_mem_we;
  logic [7:0]  b_mem_wdata, b_mem_rdata;

  logic [7:0] ram_a [0:32767];
  logic [7:0] ram_b [0:32767];

  always @(posedge clk) begin
    if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= ram_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= ram_b[b_mem_addr];
  end

  spram_arbiter #(.FIXED_PRIORITY(1), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we),
    .p0_wdata(p0_wdata), .p0_ack(a_p0_ack),
    .p0_rdata(a_p0_rdata), .p0_rvalid(a_p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we),
    .p1_wdata(p1_wdata), .p1_ack(a_p1_ack),
    .p1_rdata(a_p1_rdata), .p1_rvalid(a_p1_rvalid),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  spram_arbiter #(.FIXED_PRIORITY(0), .STARVE_LIMIT(LIMIT)) dut_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we),
    .p0_wdata(p0_wdata), .p0_ack(b_p0_ack),
    .p0_rdata(b_p0_rdata), .p0_rvalid(b_p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we),
    .p1_wdata(p1_wdata), .p1_ack(b_p1_ack),
    .p1_rdata(b_p1_rdata), .p1_rvalid(b_p1_rvalid),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Reference model: memory updated in accept order, reads return
  // the value current at accept time, two edges later.
  typedef struct {
    int         e;
    bit         p;
    logic [7:0] d;
  } ret_t;

  ret_t        q[$];
  logic [7:0]  mm [0:32767];
  int          s;
  bit          l1, l1b;
  bit          ev [2];
  logic [7:0]  erd [2];
  bit          ewe;
  logic [14:0] ead;
  logic [7:0]  ewd;
  int          ec;
  bit          x0, x1;

  int vectors = 0;
  int errs = 0;

  function automatic void rule(input bit fixed, input int sc,
                               input bit lst,
                               output bit e0, output bit e1);
    bit r0, r1;
    r0 = (p0_req === 1'b1) && (reset !== 1'b1);
    r1 = (p1_req === 1'b1) && (reset !== 1'b1);
    e0 = 1'b0;
    e1 = 1'b0;
    if (r0 && r1) begin
      if (fixed ? (sc == LIMIT) : !lst) e1 = 1'b1;
      else e0 = 1'b1;
    end else begin
      e0 = r0;
      e1 = r1;
    end
  endfunction

  task automatic edge_update();
    bit e0, e1, f0, f1, we;
    logic [14:0] ad;
    logic [7:0]  wd;
    rule(1'b1, s, l1, e0, e1);
    rule(1'b0, 0, l1b, f0, f1);
    ec++;
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    x0 = 1'b0;
    x1 = 1'b0;
    if (reset) begin
      q.delete();
      s = 0; l1 = 1'b1; l1b = 1'b1;
      erd[0] = '0; erd[1] = '0;
      ewe = 1'b0; ead = '0; ewd = '0;
      return;
    end
    if (q.size() > 0 && q[0].e + 2 == ec) begin
      ev[q[0].p] = 1'b1;
      erd[q[0].p] = q[0].d;
      void'(q.pop_front());
    end
    ewe = 1'b0;
    if (e0 || e1) begin
      we = e1 ? p1_we : p0_we;
      ad = e1 ? p1_addr : p0_addr;
      wd = e1 ? p1_wdata : p0_wdata;
      if (we) begin
        mm[ad] = wd;
        ewe = 1'b1;
      end else begin
        q.push_back('{ec, e1, mm[ad]});
      end
      ead = ad;
      ewd = wd;
      l1 = e1;
    end
    if (e1) s = 0;
    else if (p1_req && s < LIMIT) s++;
    if (f0 || f1) l1b = f1;
    x0 = e0;
    x1 = e1;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_update();
    @(negedge clk);
  endtask

  task automatic set_p(input int p, input bit rq, input bit we,
                       input logic [14:0] ad, input logic [7:0] wd);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_addr = ad; p0_wdata = wd;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = ad; p1_wdata = wd;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_p(0, 0, 0, 15'h0, 8'h0);
    set_p(1, 0, 0, 15'h0, 8'h0);
    tick();
    tick();
    p0_req = 1'b1;
    p1_req = 1'b1;
    #1;
    vectors++;
    if ({a_p0_ack, a_p1_ack, b_p0_ack, b_p1_ack} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ack got=%b%b%b%b want=0000",
               a_p0_ack, a_p1_ack, b_p0_ack, b_p1_ack);
    end
    vectors++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata} !== 24'h0) begin
      errs++;
      $display("FAIL reset_mem got we=%b a=%h d=%h want 0",
               a_mem_we, a_mem_addr, a_mem_wdata);
    end
    vectors++;
    if ({a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata}
        !== 18'h0) begin
      errs++;
      $display("FAIL reset_rd got v=%b%b d=%h %h want 0",
               a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int seen = -1;
    int nrv = 0;
    bit p1v = 1'b0;
    logic [7:0] dat = '0;
    set_p(0, 1, 1, 15'h1234, 8'h5A);
    #1;
    vectors++;
    if (a_p0_ack !== 1'b1) begin
      errs++;
      $display("FAIL wr_ack got=%b want=1", a_p0_ack);
    end
    tick();
    set_p(0, 1, 0, 15'h1234, 8'h00);
    #1;
    vectors++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 15'h1234, 8'h5A}) begin
      errs++;
      $display("FAIL wr_mem got we=%b a=%h d=%h want 1 1234 5a",
               a_mem_we, a_mem_addr, a_mem_wdata);
    end
    tick();
    p0_req = 1'b0;
    for (int c = 2; c < 8; c++) begin
      #1;
      if (c == 2) begin
        vectors++;
        if (a_mem_we !== 1'b0) begin
          errs++;
          $display("FAIL wr_we_pulse got=%b want=0", a_mem_we);
        end
      end
      if (a_p0_rvalid === 1'b1) begin
        nrv++;
        if (seen < 0) begin
          seen = c;
          dat = a_p0_rdata;
        end
      end
      if (a_p1_rvalid !== 1'b0) p1v = 1'b1;
      tick();
    end
    vectors++;
    if (seen != 4 || nrv != 1 || dat !== 8'h5A) begin
      errs++;
      $display("FAIL rd_latency got cyc=%0d n=%0d d=%h want 4 1 5a",
               seen, nrv, dat);
    end
    vectors++;
    if (p1v) begin
      errs++;
      $display("FAIL rd_p1_quiet got p1_rvalid=1 want=0");
    end
  endtask

  task automatic test_back_to_back();
    bit rv;
    for (int i = 0; i < 4; i++) begin
      set_p(0, 1, 1, 15'(i), 8'(8'h10 + i));
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      if (c < 4) set_p(0, 1, 0, 15'(c), 8'h00);
      else p0_req = 1'b0;
      #1;
      if (c < 4) begin
        vectors++;
        if (a_p0_ack !== 1'b1) begin
          errs++;
          $display("FAIL b2b_ack cyc=%0d got=%b want=1", c, a_p0_ack);
        end
      end
      rv = (c >= 3 && c <= 6);
      vectors++;
      if (a_p0_rvalid !== rv ||
          (rv && a_p0_rdata !== 8'(8'h10 + c - 3))) begin
        errs++;
        $display("FAIL b2b_rd cyc=%0d got v=%b d=%h want v=%b d=%h",
                 c, a_p0_rvalid, a_p0_rdata, rv, 8'(8'h10 + c - 3));
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    bit e1;
    do_reset();
    set_p(0, 1, 0, 15'h0, 8'h0);
    set_p(1, 1, 0, 15'h1, 8'h0);
    for (int c = 0; c < 15; c++) begin
      #1;
      e1 = (c % 5 == 4);
      vectors++;
      if ({a_p0_ack, a_p1_ack} !== {!e1, e1}) begin
        errs++;
        $display("FAIL starve_ack cyc=%0d got=%b%b want=%b%b",
                 c, a_p0_ack, a_p1_ack, !e1, e1);
      end
      vectors++;
      if (a_p0_rvalid !== ev[0] || a_p1_rvalid !== ev[1] ||
          (ev[0] && a_p0_rdata !== 8'h10) ||
          (ev[1] && a_p1_rdata !== 8'h11)) begin
        errs++;
        $display("FAIL starve_rd cyc=%0d got v=%b%b want v=%b%b",
                 c, a_p0_rvalid, a_p1_rvalid, ev[0], ev[1]);
      end
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_round_robin();
    bit v0, v1;
    do_reset();
    set_p(0, 1, 0, 15'h0, 8'h0);
    set_p(1, 1, 0, 15'h1, 8'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if ({b_p0_ack, b_p1_ack} !== {c[0] == 1'b0, c[0] == 1'b1}) begin
        errs++;
        $display("FAIL rr_ack cyc=%0d got=%b%b", c, b_p0_ack, b_p1_ack);
      end
      v0 = (c >= 3) && c[0];
      v1 = (c >= 3) && !c[0];
      vectors++;
      if (b_p0_rvalid !== v0 || b_p1_rvalid !== v1 ||
          (v0 && b_p0_rdata !== 8'h10) ||
          (v1 && b_p1_rdata !== 8'h11)) begin
        errs++;
        $display("FAIL rr_rd cyc=%0d got v=%b%b d=%h %h want v=%b%b",
                 c, b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata,
                 v0, v1);
      end
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_hazard();
    int seen = -1;
    logic [7:0] dat = '0;
    set_p(0, 1, 1, 15'h7FFF, 8'hA5);
    tick();
    p0_req = 1'b0;
    set_p(1, 1, 0, 15'h7FFF, 8'h00);
    for (int c = 1; c < 7; c++) begin
      #1;
      if (a_p1_rvalid === 1'b1 && seen < 0) begin
        seen = c;
        dat = a_p1_rdata;
      end
      tick();
      p1_req = 1'b0;
    end
    vectors++;
    if (seen != 4 || dat !== 8'hA5) begin
      errs++;
      $display("FAIL hazard got cyc=%0d d=%h want 4 a5", seen, dat);
    end
  endtask

  task automatic test_reset_midflight();
    set_p(1, 1, 0, 15'h7FFF, 8'h00);
    tick();
    reset = 1'b1;
    set_p(0, 1, 0, 15'h0002, 8'h00);
    for (int c = 1; c < 3; c++) begin
      #1;
      vectors++;
      if ({a_p0_ack, a_p1_ack} !== 2'b00) begin
        errs++;
        $display("FAIL rst_ack cyc=%0d got=%b%b want=00",
                 c, a_p0_ack, a_p1_ack);
      end
      if (c == 2) begin
        vectors++;
        if (a_mem_we !== 1'b0 || a_mem_addr !== 15'h0) begin
          errs++;
          $display("FAIL rst_mem got we=%b a=%h want 0 0",
                   a_mem_we, a_mem_addr);
        end
      end
      tick();
    end
    reset = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    for (int c = 3; c < 8; c++) begin
      #1;
      vectors++;
      if ({a_p0_rvalid, a_p1_rvalid} !== 2'b00) begin
        errs++;
        $display("FAIL rst_flush cyc=%0d got v=%b%b want 00",
                 c, a_p0_rvalid, a_p1_rvalid);
      end
      tick();
    end
  endtask

  task automatic rnd_port(input int p);
    bit rq;
    logic [14:0] ad;
    rq = ($urandom_range(0, 9) < 7);
    ad = ($urandom_range(0, 4) == 0) ? 15'h7FFF
                                     : 15'($urandom_range(0, 7));
    set_p(p, rq, 1'($urandom_range(0, 1)), ad, 8'($urandom));
  endtask

  task automatic test_random();
    bit e0, e1, f0, f1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!p0_req || x0) rnd_port(0);
      if (!p1_req || x1) rnd_port(1);
      #1;
      rule(1'b1, s, l1, e0, e1);
      rule(1'b0, 0, l1b, f0, f1);
      vectors++;
      if ({a_p0_ack, a_p1_ack} !== {e0, e1}) begin
        errs++;
        $display("FAIL rnd_ack cyc=%0d got=%b%b want=%b%b",
                 c, a_p0_ack, a_p1_ack, e0, e1);
      end
      vectors++;
      if ({b_p0_ack, b_p1_ack} !== {f0, f1}) begin
        errs++;
        $display("FAIL rnd_rr_ack cyc=%0d got=%b%b want=%b%b",
                 c, b_p0_ack, b_p1_ack, f0, f1);
      end
      vectors++;
      if (a_p0_rvalid !== ev[0] || a_p1_rvalid !== ev[1] ||
          a_p0_rdata !== erd[0] || a_p1_rdata !== erd[1]) begin
        errs++;
        $display("FAIL rnd_rd cyc=%0d got v=%b%b d=%h %h want v=%b%b d=%h %h",
                 c, a_p0_rvalid, a_p1_rvalid, a_p0_rdata, a_p1_rdata,
                 ev[0], ev[1], erd[0], erd[1]);
      end
      vectors++;
      if (a_mem_we !== ewe || a_mem_addr !== ead ||
          a_mem_wdata !== ewd) begin
        errs++;
        $display("FAIL rnd_mem cyc=%0d got we=%b a=%h d=%h want %b %h %h",
                 c, a_mem_we, a_mem_addr, a_mem_wdata, ewe, ead, ewd);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
      mm[i] = '0;
    end
    s = 0; l1 = 1'b1; l1b = 1'b1; ec = 0;
    ev[0] = 1'b0; ev[1] = 1'b0;
    erd[0] = '0; erd[1] = '0;
    ewe = 1'b0; ead = '0; ewd = '0;
    x0 = 1'b0; x1 = 1'b0;
    reset = 1'b1;
    set_p(0, 0, 0, 15'h0, 8'h0);
    set_p(1, 0, 0, 15'h0, 8'h0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_starvation();
    test_round_robin();
    test_hazard();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
